// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared constants for the HI/LO multiply/divide unit:
//                op codes, FSM state encoding, divide-by-zero fill value,
//                and a small op-class helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    // Op codes presented on the op port
    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;
    localparam logic [2:0] c_OP_MADD  = 3'b110;
    localparam logic [2:0] c_OP_MSUB  = 3'b111;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    // LO is filled with this bit replicated on a divide by zero
    localparam logic c_DIV0_FILL_BIT = 1'b1;

    // Ops that run through the multiply pipeline
    function automatic logic isMulOp(input logic [2:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_MADD) || (op == c_OP_MSUB);
    endfunction

    // Ops that run through the iterative divider
    function automatic logic isDivOp(input logic [2:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mdu_if.sv
// ============================================================================
//  Module      : hilo_mdu_if
//  Description : Request/result bundle between the EX stage (master) and
//                the HI/LO multiply/divide unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
//  Module      : mdu_divider
//  Description : Unsigned iterative restoring radix-2 divider. Loads the
//                operands on start, then produces one quotient bit per cycle
//                for WIDTH cycles. ready is high whenever no division is
//                running; abort drops an in-flight division.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic                  ready,
    output logic [WIDTH-1:0]      quotient,
    output logic [WIDTH-1:0]      remainder
);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic [c_CNT_W-1:0] r_count;
    logic               r_running;

    // Partial remainder shifted left with the next dividend bit brought in;
    // one extra bit because the shifted value can reach 2*divisor-1.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    // Load operands on start, then one restoring step per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (abort) begin
            r_running <= 1'b0;
        end else if (start) begin
            r_quo     <= dividend;
            r_rem     <= '0;
            r_div     <= divisor;
            r_count   <= c_CNT_W'(WIDTH);
            r_running <= 1'b1;
        end else if (r_running) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_count <= r_count - c_CNT_W'(1);
            if (r_count == c_CNT_W'(1)) begin
                r_running <= 1'b0;
            end
        end
    end

    assign ready     = !r_running;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/hilo_mdu.sv
// ============================================================================
//  Module      : hilo_mdu
//  Description : Multiply/divide unit owning the MIPS HI/LO register pair.
//                MULT/MULTU commit after MUL_CYCLES, DIV/DIVU after WIDTH
//                divider iterations plus one sign-fixup cycle. MTHI/MTLO
//                write immediately. busy stalls dependent instructions.
//                Build option: define HILO_MDU_MADD_EN to enable the signed
//                multiply-accumulate ops MADD/MSUB (op 110/111); otherwise
//                those op codes are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    hilo_mdu_if.slave bus
);
    import mdu_pkg::*;

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    // Architectural and control state
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_srcA;
    logic [WIDTH-1:0]   r_srcB;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Accept control
    logic               w_opLegal;
    logic               w_accept;
    logic               w_countZero;

    // Multiply datapath (magnitudes multiplied, sign applied afterwards)
    logic               w_mulSigned;
    logic               w_mulANeg;
    logic               w_mulBNeg;
    logic [WIDTH-1:0]   w_mulAbsA;
    logic [WIDTH-1:0]   w_mulAbsB;
    logic [2*WIDTH-1:0] w_uProd;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mulResult;

    // Divide datapath
    logic               w_inDivSigned;
    logic               w_inANeg;
    logic               w_inBNeg;
    logic [WIDTH-1:0]   w_inAbsA;
    logic [WIDTH-1:0]   w_inAbsB;
    logic               w_divStart;
    logic               w_divReady;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_divSigned;
    logic               w_quoNeg;
    logic               w_remNeg;
    logic               w_divByZero;
    logic [WIDTH-1:0]   w_divHi;
    logic [WIDTH-1:0]   w_divLo;

`ifdef HILO_MDU_MADD_EN
    assign w_opLegal = 1'b1;
`else
    assign w_opLegal = (bus.op != c_OP_MADD) && (bus.op != c_OP_MSUB);
`endif

    // A flush in the same cycle always wins over a new request
    assign w_accept    = bus.start && (r_state == c_ST_IDLE) && !bus.flush && w_opLegal;
    assign w_countZero = (r_count == '0);

    // Only MULTU treats its operands as unsigned; MADD/MSUB are signed
    assign w_mulSigned = (r_op != c_OP_MULTU);
    assign w_mulANeg   = w_mulSigned & r_srcA[WIDTH-1];
    assign w_mulBNeg   = w_mulSigned & r_srcB[WIDTH-1];
    assign w_mulAbsA   = w_mulANeg ? -r_srcA : r_srcA;
    assign w_mulAbsB   = w_mulBNeg ? -r_srcB : r_srcB;
    assign w_uProd     = {{WIDTH{1'b0}}, w_mulAbsA} * {{WIDTH{1'b0}}, w_mulAbsB};
    assign w_prod      = (w_mulANeg ^ w_mulBNeg) ? -w_uProd : w_uProd;

`ifdef HILO_MDU_MADD_EN
    // Accumulate against HI/LO as they stand at the commit edge
    always_comb begin
        w_mulResult = w_prod;
        case (r_op)
            c_OP_MADD: w_mulResult = {r_hi, r_lo} + w_prod;
            c_OP_MSUB: w_mulResult = {r_hi, r_lo} - w_prod;
            default:   w_mulResult = w_prod;
        endcase
    end
`else
    assign w_mulResult = w_prod;
`endif

    // Divider is fed magnitudes straight from the request at accept time
    assign w_inDivSigned = (bus.op == c_OP_DIV);
    assign w_inANeg      = w_inDivSigned & bus.srca[WIDTH-1];
    assign w_inBNeg      = w_inDivSigned & bus.srcb[WIDTH-1];
    assign w_inAbsA      = w_inANeg ? -bus.srca : bus.srca;
    assign w_inAbsB      = w_inBNeg ? -bus.srcb : bus.srcb;
    assign w_divStart    = w_accept && isDivOp(bus.op);

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (w_divStart),
        .abort     (bus.flush),
        .dividend  (w_inAbsA),
        .divisor   (w_inAbsB),
        .ready     (w_divReady),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Sign fixup: quotient truncates toward zero, remainder follows dividend.
    // MIN / -1 needs no special case: |MIN| / 1 = MIN with a positive sign.
    assign w_divSigned = (r_op == c_OP_DIV);
    assign w_quoNeg    = w_divSigned & (r_srcA[WIDTH-1] ^ r_srcB[WIDTH-1]);
    assign w_remNeg    = w_divSigned & r_srcA[WIDTH-1];
    assign w_divByZero = (r_srcB == '0);
    assign w_divLo     = w_divByZero ? {WIDTH{c_DIV0_FILL_BIT}} : (w_quoNeg ? -w_quo : w_quo);
    assign w_divHi     = w_divByZero ? r_srcA : (w_remNeg ? -w_rem : w_rem);

    // Control FSM, operand latches and HI/LO update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_op    <= c_OP_MULT;
            r_srcA  <= '0;
            r_srcB  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= bus.op;
                        r_srcA <= bus.srca;
                        r_srcB <= bus.srcb;
                        case (bus.op)
                            c_OP_MTHI: r_hi <= bus.srca;
                            c_OP_MTLO: r_lo <= bus.srca;
                            c_OP_DIV, c_OP_DIVU: begin
                                r_state <= c_ST_DIV;
                                r_count <= c_CNT_W'(WIDTH - 1);
                            end
                            default: begin
                                r_state <= c_ST_MUL;
                                r_count <= c_CNT_W'(MUL_CYCLES - 1);
                            end
                        endcase
                    end
                end
                c_ST_MUL: begin
                    if (bus.flush) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_countZero) begin
                        {r_hi, r_lo} <= w_mulResult;
                        r_done       <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end else begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                end
                c_ST_DIV: begin
                    if (bus.flush) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_countZero) begin
                        r_state <= c_ST_FIX;
                    end else begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                end
                c_ST_FIX: begin
                    if (bus.flush) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_divReady) begin
                        r_hi    <= w_divHi;
                        r_lo    <= w_divLo;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != c_ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire
